// File: rtl/abro_sequence_generator.sv
// ABRO stimulus generator: expands one (arm, fire, count) command into a
// cycle-exact A/B waveform, plus the detector output O_exp expected for each cycle.
//
// state   | meaning
// IDLE    | A=0 B=0, accepting commands
// ARM     | A=1 B=0, lasts max(arm,1) cycles
// FIRE    | A=1 B=1, lasts max(fire,1) cycles
// RELEASE | A=0 B=1, one cycle, closes a token
module abro_sequence_generator #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_arm,
   input  logic [LEN_W-1:0] cmd_fire,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             abort,
   output logic             A,
   output logic             B,
   output logic             O_exp,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] tokens
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_FIRE = 2'd2;
   localparam logic [1:0] S_REL  = 2'd3;

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [LEN_W-1:0] phase_q, phase_d;
   logic [LEN_W-1:0] arm_q, arm_d;
   logic [LEN_W-1:0] fire_q, fire_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] tokens_q, tokens_d;
   logic             abort_pend_q, abort_pend_d;
   logic             a_q, a_d;
   logic             b_q, b_d;
   logic             o_exp_q, o_exp_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [LEN_W-1:0] arm_len;
   logic [LEN_W-1:0] fire_len;

   // zero-length phases are stretched to one cycle
   assign arm_len  = (cmd_arm  == '0) ? LEN_ONE : cmd_arm;
   assign fire_len = (cmd_fire == '0) ? LEN_ONE : cmd_fire;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      arm_d        = arm_q;
      fire_d       = fire_q;
      rem_d        = rem_q;
      tokens_d     = tokens_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               arm_d        = arm_len;
               fire_d       = fire_len;
               rem_d        = cmd_count;
               tokens_d     = '0;
               abort_pend_d = 1'b0;
               if (cmd_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_ARM;
                  phase_d = arm_len - LEN_ONE;
               end
            end
         end
         S_ARM: begin
            if (abort) begin
               state_d      = S_REL;
               abort_pend_d = 1'b1;
            end else if (phase_q == '0) begin
               state_d = S_FIRE;
               phase_d = fire_q - LEN_ONE;
            end else begin
               phase_d = phase_q - LEN_ONE;
            end
         end
         S_FIRE: begin
            if (abort) begin
               state_d      = S_REL;
               abort_pend_d = 1'b1;
            end else if (phase_q == '0) begin
               state_d = S_REL;
            end else begin
               phase_d = phase_q - LEN_ONE;
            end
         end
         S_REL: begin
            tokens_d = tokens_q + CNT_ONE;
            rem_d    = rem_q - CNT_ONE;
            if (abort || abort_pend_q || (rem_q == CNT_ONE)) begin
               state_d      = S_IDLE;
               done_d       = 1'b1;
               abort_pend_d = 1'b0;
            end else begin
               state_d = S_ARM;
               phase_d = arm_q - LEN_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // outputs are registered from the next state so they line up with it
   always_comb begin
      a_d     = (state_d == S_ARM) || (state_d == S_FIRE);
      b_d     = (state_d == S_FIRE) || (state_d == S_REL);
      o_exp_d = (state_d == S_FIRE) && (state_q == S_FIRE);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         phase_q      <= '0;
         arm_q        <= '0;
         fire_q       <= '0;
         rem_q        <= '0;
         tokens_q     <= '0;
         abort_pend_q <= 1'b0;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         o_exp_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         arm_q        <= arm_d;
         fire_q       <= fire_d;
         rem_q        <= rem_d;
         tokens_q     <= tokens_d;
         abort_pend_q <= abort_pend_d;
         a_q          <= a_d;
         b_q          <= b_d;
         o_exp_q      <= o_exp_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign A         = a_q;
   assign B         = b_q;
   assign O_exp     = o_exp_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign tokens    = tokens_q;

endmodule

// File: tb/tb_abro_sequence_generator.sv
// Bench for abro_sequence_generator: a per-cycle expectation queue built from
// the command (token = arm run, fire run, one release) checked every cycle.
module tb_abro_sequence_generator;

   typedef struct packed {
      logic       a;
      logic       b;
      logic       o;
      logic       busy;
      logic       done;
      logic [7:0] tokens;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_arm = '0;
   logic [7:0] cmd_fire = '0;
   logic [7:0] cmd_count = '0;
   logic       abort = 1'b0;
   logic       A, B, O_exp, busy, done;
   logic [7:0] tokens;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   o_high = 0;
   ent_t exp_q[$];
   ent_t cur;
   logic [7:0] idle_tokens = '0;

   abro_sequence_generator #(.LEN_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_arm(cmd_arm), .cmd_fire(cmd_fire), .cmd_count(cmd_count), .abort(abort),
      .A(A), .B(B), .O_exp(O_exp), .busy(busy), .done(done), .tokens(tokens)
   );

   always #5 clk = ~clk;

   function automatic ent_t mk(input logic a, input logic b, input logic o,
                               input logic bsy, input logic dn, input logic [7:0] tk);
      ent_t e;
      e.a = a; e.b = b; e.o = o; e.busy = bsy; e.done = dn; e.tokens = tk;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
      end
   endtask

   // advance one clock, then compare every output against the model's entry
   task automatic step();
      logic [31:0] act, expv;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle_tokens);
      idle_tokens = cur.tokens;
      act  = {18'd0, A, B, O_exp, busy, done, cmd_ready, tokens};
      expv = {18'd0, cur.a, cur.b, cur.o, cur.busy, cur.done, ~(cur.a | cur.b), cur.tokens};
      chk("outputs{A,B,O,busy,done,ready,tokens}", act, expv);
      o_high += int'(O_exp);
   endtask

   task automatic send(input int arm, input int fire, input int count);
      int al, fl;
      cmd_valid = 1'b1;
      cmd_arm   = 8'(arm);
      cmd_fire  = 8'(fire);
      cmd_count = 8'(count);
      al = (arm == 0) ? 1 : arm;
      fl = (fire == 0) ? 1 : fire;
      for (int t = 0; t < count; t++) begin
         for (int i = 0; i < al; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'(t)));
         for (int i = 0; i < fl; i++) exp_q.push_back(mk(1'b1, 1'b1, i > 0, 1'b1, 1'b0, 8'(t)));
         exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'(t)));
      end
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(count)));
   endtask

   task automatic issue(input int arm, input int fire, input int count);
      send(arm, fire, count);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      while (exp_q.size() > 0) step();
      step();
   endtask

   // abort in the cycle just checked: cut the rest of the sequence short
   task automatic do_abort();
      abort = 1'b1;
      if (cur.a) begin
         exp_q.delete();
         exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, cur.tokens));
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur.tokens + 8'd1));
      end else if (cur.b) begin
         exp_q.delete();
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cur.tokens + 8'd1));
      end
      step();
      abort = 1'b0;
   endtask

   initial begin
      logic [11:0] abv;
      logic [5:0]  ov;

      #2;
      chk("reset_outputs", {26'd0, A, B, O_exp, busy, done, cmd_ready}, 32'h1);
      chk("reset_tokens", {24'd0, tokens}, 32'd0);
      #16 rst_n = 1'b1;
      step();
      step();

      // single token, with the model itself pinned to the hand-derived waveform
      send(2, 3, 1);
      abv = '0;
      ov  = '0;
      for (int i = 0; i < 6; i++) begin
         abv = {abv[9:0], exp_q[i].a, exp_q[i].b};
         ov  = {ov[4:0], exp_q[i].o};
      end
      chk("model_single_ab", {20'd0, abv}, {20'd0, 12'b10_10_11_11_11_01});
      chk("model_single_o", {26'd0, ov}, {26'd0, 6'b000110});
      chk("model_single_len", exp_q.size(), 7);
      step();
      cmd_valid = 1'b0;
      drain();
      chk("single_tokens", {24'd0, tokens}, 32'd1);

      // back-to-back tokens; a stray cmd_valid mid-sequence must be ignored
      o_high = 0;
      issue(1, 2, 3);
      step();
      cmd_valid = 1'b1; cmd_arm = 8'd9; cmd_fire = 8'd9; cmd_count = 8'd9;
      step();
      step();
      cmd_valid = 1'b0;
      drain();
      chk("b2b_o_high_count", o_high, 3);
      chk("b2b_tokens", {24'd0, tokens}, 32'd3);

      // zero-length fields
      o_high = 0;
      issue(0, 0, 2);
      drain();
      chk("zero_fields_o_never", o_high, 0);

      // count=0, then a command accepted in the done cycle
      issue(4, 4, 0);
      chk("count0_done", {31'd0, done}, 32'd1);
      issue(1, 1, 1);
      chk("after_done_arm", {30'd0, A, B}, 32'b10);
      drain();

      // abort in the 2nd FIRE cycle
      issue(1, 5, 4);
      step();
      step();
      do_abort();
      step();
      chk("abort_fire_tokens", {24'd0, tokens}, 32'd1);
      drain();

      // abort during RELEASE of token 2
      issue(1, 1, 5);
      repeat (5) step();
      do_abort();
      chk("abort_rel_done", {31'd0, done}, 32'd1);
      chk("abort_rel_tokens", {24'd0, tokens}, 32'd2);
      drain();

      // abort while idle is ignored
      abort = 1'b1;
      step();
      step();
      abort = 1'b0;

      // maximum lengths and count
      issue(255, 255, 1);
      drain();
      issue(0, 0, 255);
      drain();
      chk("max_count_tokens", {24'd0, tokens}, 32'd255);

      // asynchronous reset mid-ARM, off the clock edge
      issue(3, 2, 2);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {26'd0, A, B, O_exp, busy, done, cmd_ready}, 32'h1);
      chk("async_rst_tokens", {24'd0, tokens}, 32'd0);
      exp_q.delete();
      idle_tokens = '0;
      #2 rst_n = 1'b1;
      step();
      step();
      step();
      issue(1, 2, 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
